pipe_datapath: RTL and testbench

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/pipe_datapath.sv | 110 +++++++++++
 tb/tb_pipe_datapath.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_datapath.sv
// Two-stage integer datapath: combinational read + ALU at issue, one registered writeback slot.
// Define PIPE_DATAPATH_FWD_EN to forward slot data to issuing operands instead of stalling.
module pipe_datapath #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG),
   localparam int SW   = $clog2(XLEN)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic            use_imm,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   input  logic            reg_write,
   input  logic [XLEN-1:0] imm,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_data,
   output logic [AW-1:0]   res_rd
);

   logic [XLEN-1:0] r_rf [NREG];
   logic            r_vld;
   logic            r_we;
   logic [AW-1:0]   r_rd;
   logic [XLEN-1:0] r_data;

   logic            w_slot_dst;
   logic            w_retire;
   logic            w_wr_en;
   logic            w_issue;
   logic            w_hazard;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_rs2_val;
   logic [XLEN-1:0] w_b;
   logic [SW-1:0]   w_shamt;
   logic [XLEN-1:0] w_alu;

   assign w_slot_dst = r_vld && r_we && (r_rd != '0);
   assign w_retire   = r_vld && res_ready;
   assign w_wr_en    = w_retire && w_slot_dst;

`ifdef PIPE_DATAPATH_FWD_EN
   // Slot data is the newest value of its rd whether or not it retires this cycle.
   assign w_a       = (rs1 == '0) ? '0 : (w_slot_dst && rs1 == r_rd) ? r_data : r_rf[rs1];
   assign w_rs2_val = (rs2 == '0) ? '0 : (w_slot_dst && rs2 == r_rd) ? r_data : r_rf[rs2];
   assign w_hazard  = 1'b0;
`else
   assign w_a       = (rs1 == '0) ? '0 : (w_wr_en && rs1 == r_rd) ? r_data : r_rf[rs1];
   assign w_rs2_val = (rs2 == '0) ? '0 : (w_wr_en && rs2 == r_rd) ? r_data : r_rf[rs2];
   assign w_hazard  = w_slot_dst && ((rs1 == r_rd) || (!use_imm && rs2 == r_rd));
`endif

   assign w_b     = use_imm ? imm : w_rs2_val;
   assign w_shamt = w_b[SW-1:0];

   always_comb begin
      w_alu = '0;
      case (op)
         4'd0:    w_alu = w_a + w_b;
         4'd1:    w_alu = w_a - w_b;
         4'd2:    w_alu = w_a & w_b;
         4'd3:    w_alu = w_a | w_b;
         4'd4:    w_alu = w_a ^ w_b;
         4'd5:    w_alu = w_a << w_shamt;
         4'd6:    w_alu = w_a >> w_shamt;
         4'd7:    w_alu = $signed(w_a) >>> w_shamt;
         4'd8:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         4'd9:    w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
         default: w_alu = '0;
      endcase
   end

   assign in_ready = (!r_vld || res_ready) && !w_hazard;
   assign w_issue  = in_valid && in_ready;

   // A new issue on the retire edge reloads the slot, giving one instruction per cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_vld  <= 1'b0;
         r_we   <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
      end else if (w_issue) begin
         r_vld  <= 1'b1;
         r_we   <= reg_write;
         r_rd   <= rd;
         r_data <= w_alu;
      end else if (w_retire) begin
         r_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (w_wr_en) begin
         r_rf[r_rd] <= r_data;
      end
   end

   assign res_valid = r_vld;
   assign res_data  = r_data;
   assign res_rd    = r_rd;

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: sequential-ISA reference model with per-cycle compare, plus literal checks.
module tb_pipe_datapath;
   localparam int XL = 32, NR = 32, AW = 5;
`ifdef PIPE_DATAPATH_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif
   localparam logic [3:0] ADD = 0, SUB = 1, SLL = 5, SRL = 6, SRA = 7, SLT = 8, SLTU = 9;

   logic clock = 0, reset = 0;
   logic in_valid = 0, in_ready, use_imm = 0, reg_write = 0, res_valid, res_ready = 1;
   logic [3:0] op = 0;
   logic [AW-1:0] rs1 = 0, rs2 = 0, rd = 0, res_rd;
   logic [XL-1:0] imm = 0, res_data;

   logic s_in_valid = 0, s_in_ready, s_use_imm = 0, s_reg_write = 0, s_res_valid, s_res_ready = 1;
   logic [3:0] s_op = 0;
   logic [2:0] s_rs1 = 0, s_rs2 = 0, s_rd = 0, s_res_rd;
   logic [15:0] s_imm = 0, s_res_data;

   int n_chk = 0, n_pass = 0;

   always #5 clock = ~clock;

   pipe_datapath u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .use_imm(use_imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .imm(imm),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd));

   pipe_datapath #(.XLEN(16), .NREG(8)) u_sm (
      .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .use_imm(s_use_imm), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .reg_write(s_reg_write),
      .imm(s_imm), .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data),
      .res_rd(s_res_rd));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference: instructions take effect in issue order on an architectural register array.
   typedef struct { logic [AW-1:0] rd; logic we; logic [XL-1:0] data; } res_t;
   res_t          q[$];
   res_t          m_e;
   logic [XL-1:0] mreg [NR];
   logic [XL-1:0] ret_log[$];
   logic [XL-1:0] m_a, m_b;
   logic          m_hz, m_rdy;

   function automatic logic [XL-1:0] ref_alu(input logic [3:0] o, input logic [XL-1:0] a, b);
      case (o)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a << b[4:0];
         6: return a >> b[4:0];
         7: return $unsigned($signed(a) >>> b[4:0]);
         8: return ($signed(a) < $signed(b)) ? 1 : 0;
         9: return (a < b) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         q.delete();
         for (int i = 0; i < NR; i++) mreg[i] = '0;
         chk("rst_res_valid", res_valid, 0);
         chk("rst_res_data", res_data, 0);
      end else begin
         chk("res_valid", res_valid, q.size() > 0);
         if (res_valid && q.size() > 0) begin
            chk("res_data", res_data, q[0].data);
            chk("res_rd", res_rd, q[0].rd);
         end
         m_hz  = q.size() > 0 && q[0].we && q[0].rd != 0 &&
                 (rs1 == q[0].rd || (!use_imm && rs2 == q[0].rd));
         m_rdy = (q.size() == 0 || res_ready) && (FWD == 1 || !m_hz);
         chk("in_ready", in_ready, m_rdy);
         if (res_valid && res_ready && q.size() > 0) begin
            ret_log.push_back(q[0].data);
            q.delete(0);
         end
         if (in_valid && in_ready) begin
            m_a = (rs1 == 0) ? '0 : mreg[rs1];
            m_b = use_imm ? imm : ((rs2 == 0) ? '0 : mreg[rs2]);
            m_e.rd = rd; m_e.we = reg_write; m_e.data = ref_alu(op, m_a, m_b);
            q.push_back(m_e);
            if (reg_write && rd != 0) mreg[rd] = m_e.data;
         end
      end
   end

   task automatic drive(input logic [3:0] o, input logic ui, input logic [AW-1:0] a, b, d,
                        input logic w, input logic [XL-1:0] im);
      op = o; use_imm = ui; rs1 = a; rs2 = b; rd = d; reg_write = w; imm = im; in_valid = 1;
   endtask

   task automatic wait_accept(output int stalls);
      logic r;
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); r = in_ready;
         @(posedge clock); #1;
         if (r) begin in_valid = 0; return; end
         stalls++;
      end
      in_valid = 0;
      n_chk++;
      $display("FAIL accept_timeout: in_ready never high within 20 cycles");
   endtask

   task automatic get_res(output logic [XL-1:0] d);
      d = 'x;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (res_valid) begin d = res_data; @(posedge clock); #1; return; end
         @(posedge clock); #1;
      end
      n_chk++;
      $display("FAIL result_timeout: res_valid never high within 20 cycles");
   endtask

   task automatic run(input logic [3:0] o, input logic ui, input logic [AW-1:0] a, b, d,
                      input logic w, input logic [XL-1:0] im, output logic [XL-1:0] r);
      int st;
      drive(o, ui, a, b, d, w, im);
      wait_accept(st);
      get_res(r);
   endtask

   task automatic s_run(input logic [3:0] o, input logic ui, input logic [2:0] a, b, d,
                        input logic [15:0] im, output logic [15:0] r);
      bit acc = 0, got = 0;
      s_op = o; s_use_imm = ui; s_rs1 = a; s_rs2 = b; s_rd = d; s_imm = im;
      s_reg_write = 1; s_in_valid = 1;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clock); acc = s_in_ready;
         @(posedge clock); #1;
      end
      s_in_valid = 0;
      r = 'x;
      for (int i = 0; i < 20 && acc && !got; i++) begin
         @(negedge clock);
         if (s_res_valid) begin r = s_res_data; got = 1; end
         @(posedge clock); #1;
      end
      if (!got) begin
         n_chk++;
         $display("FAIL sm_timeout: small instance handshake did not complete");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int st, tot;
      logic [XL-1:0] d;
      logic [15:0] sd;

      repeat (2) @(posedge clock);
      #1;
      chk("reset_valid", res_valid, 0);
      chk("reset_data", res_data, 0);
      chk("reset_rd", res_rd, 0);
      reset = 1;
      @(negedge clock);
      chk("ready_after_reset", in_ready, 1);
      @(posedge clock); #1;

      // ADDI x1=5 then ADD x2=x1+x1 back to back
      ret_log.delete();
      drive(ADD, 1, 0, 0, 1, 1, 5);  wait_accept(st);
      drive(ADD, 0, 1, 1, 2, 1, 0);  wait_accept(st);
      chk("b2b_stalls", st, (FWD == 1) ? 0 : 1);
      get_res(d);
      chk("b2b_add", d, 10);
      chk("b2b_retired", ret_log.size(), 2);
      if (ret_log.size() >= 1) chk("b2b_addi", ret_log[0], 5);

      // independent issues must stream with no bubble
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         drive(ADD, 1, 0, 0, AW'(20 + i), 1, XL'(100 + i));
         wait_accept(st);
         tot += st;
      end
      chk("stream_stalls", tot, 0);
      get_res(d);
      chk("stream_last", d, 103);

      run(ADD, 1, 0, 0, 10, 1, 1, d);
      run(SUB, 0, 0, 10, 11, 1, 0, d);            chk("sub_wrap", d, 32'hFFFF_FFFF);
      run(ADD, 1, 0, 0, 12, 1, 32'h8000_0000, d);
      run(SRA, 1, 12, 0, 13, 1, 4, d);            chk("sra", d, 32'hF800_0000);
      run(SRL, 1, 12, 0, 16, 1, 32'h24, d);       chk("srl_shamt_mask", d, 32'h0800_0000);
      run(SLTU, 0, 10, 11, 14, 1, 0, d);          chk("sltu", d, 1);
      run(SLT, 0, 10, 11, 15, 1, 0, d);           chk("slt", d, 0);
      run(4'd12, 1, 10, 0, 17, 1, 7, d);          chk("op12_zero", d, 0);

      // stalled consumer: slot holds, nothing issues
      res_ready = 0;
      drive(ADD, 1, 0, 0, 4, 1, 7); wait_accept(st);
      drive(ADD, 1, 0, 0, 6, 1, 9);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("hold_ready", in_ready, 0);
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, 7);
         chk("hold_rd", res_rd, 4);
         @(posedge clock); #1;
      end
      res_ready = 1;
      wait_accept(st);
      get_res(d);                                 chk("after_hold", d, 9);
      run(ADD, 0, 4, 0, 7, 1, 0, d);              chk("x4_written", d, 7);

      run(ADD, 1, 0, 0, 0, 1, 32'h1234, d);       chk("x0_result", d, 32'h1234);
      run(ADD, 1, 0, 0, 8, 1, 3, d);
      run(ADD, 0, 0, 8, 8, 1, 0, d);              chk("x0_reads_zero", d, 3);
      run(ADD, 1, 0, 0, 3, 1, 33, d);
      run(ADD, 1, 0, 0, 3, 0, 99, d);             chk("nowrite_result", d, 99);
      run(ADD, 0, 3, 0, 9, 1, 0, d);              chk("x3_unchanged", d, 33);

      // reset while a write to x5 is still in the slot
      res_ready = 0;
      drive(ADD, 1, 0, 0, 5, 1, 32'h55); wait_accept(st);
      #2 reset = 0;
      #1;
      chk("midrst_valid", res_valid, 0);
      chk("midrst_data", res_data, 0);
      chk("midrst_rd", res_rd, 0);
      @(posedge clock); #1;
      reset = 1; res_ready = 1;
      run(ADD, 0, 5, 0, 18, 1, 0, d);             chk("x5_dropped", d, 0);
      run(ADD, 0, 3, 0, 19, 1, 0, d);             chk("x3_cleared", d, 0);

      // XLEN=16, NREG=8 instance
      s_run(ADD, 1, 0, 0, 1, 16'hFFFF, sd);       chk("sm_addi", sd, 16'hFFFF);
      s_run(ADD, 1, 1, 0, 2, 16'h0001, sd);       chk("sm_add_wrap", sd, 16'h0000);
      s_run(ADD, 1, 0, 0, 3, 16'h0001, sd);
      s_run(SLL, 1, 3, 0, 4, 16'd17, sd);         chk("sm_sll17", sd, 16'h0002);
      s_run(SRA, 1, 1, 0, 5, 16'd3, sd);          chk("sm_sra", sd, 16'hFFFF);
      s_run(ADD, 0, 4, 2, 6, 16'd0, sd);          chk("sm_regs", sd, 16'h0002);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
